// File: rtl/cg_rvarch_instr_encoder.sv
// ============================================================================
// Module   : cg_rvarch_instr_encoder
// Brief    : Streaming RV32 instruction encoder with LI -> LUI/ADDI expansion.
//            Optional macro CG_RVARCH_ENC_CHECK_EN enables immediate checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cg_rvarch_instr_encoder #(
  parameter int          INSTR_WIDTH = 32,
  parameter logic [2:0]  ADDI_FUNCT3 = 3'b000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [2:0]             i_req_fmt,
  input  logic [6:0]             i_req_opcode,
  input  logic [4:0]             i_req_rd,
  input  logic [4:0]             i_req_rs1,
  input  logic [4:0]             i_req_rs2,
  input  logic [2:0]             i_req_funct3,
  input  logic [6:0]             i_req_funct7,
  input  logic [31:0]            i_req_imm,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_instr_last,
  output logic                   o_err
);

  localparam logic [6:0] c_op_imm = 7'b0010011;
  localparam logic [6:0] c_op_lui = 7'b0110111;

  localparam logic [2:0] c_fmt_r  = 3'd0;
  localparam logic [2:0] c_fmt_i  = 3'd1;
  localparam logic [2:0] c_fmt_s  = 3'd2;
  localparam logic [2:0] c_fmt_b  = 3'd3;
  localparam logic [2:0] c_fmt_u  = 3'd4;
  localparam logic [2:0] c_fmt_j  = 3'd5;
  localparam logic [2:0] c_fmt_li = 3'd6;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_FIRST = 2'd1,
    HOLD_LAST  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_err;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] r_pend;

  logic [INSTR_WIDTH-1:0] w_word0;
  logic [INSTR_WIDTH-1:0] w_word1;
  logic                   w_two;
  logic                   w_err;
  logic                   w_fits12;
  logic [19:0]            w_li_hi;
  logic                   w_req_ready;

  assign w_fits12 = (i_req_imm[31:11] == {21{i_req_imm[11]}});
  // Rounding the upper part up compensates for ADDI sign-extending the low 12 bits.
  assign w_li_hi  = i_req_imm[31:12] + {19'd0, i_req_imm[11]};

  always_comb begin
    w_word0 = '0;
    w_word1 = '0;
    w_two   = 1'b0;
    case (i_req_fmt)
      c_fmt_i:
        w_word0 = {i_req_imm[11:0], i_req_rs1, i_req_funct3, i_req_rd, i_req_opcode};
      c_fmt_s:
        w_word0 = {i_req_imm[11:5], i_req_rs2, i_req_rs1, i_req_funct3,
                   i_req_imm[4:0], i_req_opcode};
      c_fmt_b:
        w_word0 = {i_req_imm[12], i_req_imm[10:5], i_req_rs2, i_req_rs1, i_req_funct3,
                   i_req_imm[4:1], i_req_imm[11], i_req_opcode};
      c_fmt_u:
        w_word0 = {i_req_imm[31:12], i_req_rd, i_req_opcode};
      c_fmt_j:
        w_word0 = {i_req_imm[20], i_req_imm[10:1], i_req_imm[11], i_req_imm[19:12],
                   i_req_rd, i_req_opcode};
      c_fmt_li: begin
        if (w_fits12) begin
          w_word0 = {i_req_imm[11:0], 5'd0, ADDI_FUNCT3, i_req_rd, c_op_imm};
        end else begin
          w_word0 = {w_li_hi, i_req_rd, c_op_lui};
          w_word1 = {i_req_imm[11:0], i_req_rd, ADDI_FUNCT3, i_req_rd, c_op_imm};
          w_two   = (i_req_imm[11:0] != 12'd0);
        end
      end
      // R format, and the illegal code 7 when it is not rejected
      default:
        w_word0 = {i_req_funct7, i_req_rs2, i_req_rs1, i_req_funct3, i_req_rd, i_req_opcode};
    endcase
  end

`ifdef CG_RVARCH_ENC_CHECK_EN
  logic w_fits13;
  logic w_fits21;

  assign w_fits13 = (i_req_imm[31:12] == {20{i_req_imm[12]}});
  assign w_fits21 = (i_req_imm[31:20] == {12{i_req_imm[20]}});

  always_comb begin
    w_err = 1'b0;
    case (i_req_fmt)
      c_fmt_i, c_fmt_s: w_err = !w_fits12;
      c_fmt_b:          w_err = !w_fits13 || i_req_imm[0];
      c_fmt_j:          w_err = !w_fits21 || i_req_imm[0];
      c_fmt_u:          w_err = (i_req_imm[11:0] != 12'd0);
      3'd7:             w_err = 1'b1;
      default:          w_err = 1'b0;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  assign w_req_ready = (r_state == IDLE) || ((r_state == HOLD_LAST) && i_instr_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_instr <= '0;
      r_pend  <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_state == HOLD_FIRST) begin
        if (i_instr_ready) begin
          r_instr <= r_pend;
          r_last  <= 1'b1;
          r_state <= HOLD_LAST;
        end
      end else if (w_req_ready) begin
        if (i_req_valid && !w_err) begin
          r_valid <= 1'b1;
          r_instr <= w_word0;
          r_pend  <= w_word1;
          r_last  <= !w_two;
          r_state <= w_two ? HOLD_FIRST : HOLD_LAST;
        end else begin
          // Nothing new to present: any finished word is dropped, a bad request pulses o_err
          r_valid <= 1'b0;
          r_state <= IDLE;
          r_err   <= i_req_valid;
        end
      end
    end
  end

  assign o_req_ready   = w_req_ready;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_instr_last  = r_last;
  assign o_err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cg_rvarch_instr_encoder.sv
// ============================================================================
// Module   : tb_cg_rvarch_instr_encoder
// Brief    : Self-checking bench for cg_rvarch_instr_encoder (random + directed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cg_rvarch_instr_encoder;

`ifdef CG_RVARCH_ENC_CHECK_EN
  localparam bit c_chk = 1'b1;
`else
  localparam bit c_chk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_last;
  logic        err;

  cg_rvarch_instr_encoder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_fmt    (req_fmt),
    .i_req_opcode (req_opcode),
    .i_req_rd     (req_rd),
    .i_req_rs1    (req_rs1),
    .i_req_rs2    (req_rs2),
    .i_req_funct3 (req_funct3),
    .i_req_funct7 (req_funct7),
    .i_req_imm    (req_imm),
    .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready),
    .o_instr      (instr),
    .o_instr_last (instr_last),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  bit          exp_err  = 1'b0;
  bit          mon_en   = 1'b0;
  bit          rand_rdy = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int w);
    return (v >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  // Reference encoder straight from the ISA field layout and the LI arithmetic.
  function automatic void model(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] u,
                                output bit bad, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    longint s;
    logic [31:0] hi, lo, base;
    s    = longint'($signed(u));
    bad  = 1'b0;
    n    = 1;
    w1   = '0;
    base = (32'(rd) << 7) | 32'(op);
    if (c_chk) begin
      case (fmt)
        3'd1, 3'd2: bad = (s < -2048) || (s > 2047);
        3'd3:       bad = (s < -4096) || (s > 4094) || (u % 2 != 0);
        3'd5:       bad = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2) || (u % 2 != 0);
        3'd4:       bad = (u % 4096 != 0);
        3'd7:       bad = 1'b1;
        default:    bad = 1'b0;
      endcase
    end
    case (fmt)
      3'd1: w0 = (fld(u, 0, 12) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      3'd2: w0 = (fld(u, 5, 7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                 (32'(f3) << 12) | (fld(u, 0, 5) << 7) | 32'(op);
      3'd3: w0 = (fld(u, 12, 1) << 31) | (fld(u, 5, 6) << 25) | (32'(rs2) << 20) |
                 (32'(rs1) << 15) | (32'(f3) << 12) | (fld(u, 1, 4) << 8) |
                 (fld(u, 11, 1) << 7) | 32'(op);
      3'd4: w0 = ((u / 4096) * 4096) | base;
      3'd5: w0 = (fld(u, 20, 1) << 31) | (fld(u, 1, 10) << 21) | (fld(u, 11, 1) << 20) |
                 (fld(u, 12, 8) << 12) | base;
      3'd6: begin
        if (s >= -2048 && s <= 2047) begin
          w0 = (fld(u, 0, 12) << 20) | (32'(rd) << 7) | 32'h13;
        end else begin
          hi = (u + 32'h800) >> 12;
          lo = u % 4096;
          w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
          w1 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
          n  = (lo != 0) ? 2 : 1;
        end
      end
      default: w0 = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                    (32'(f3) << 12) | base;
    endcase
  endfunction

  // Cycle monitor: sample between edges, then predict the effect of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit          bad;
      int          n;
      logic [31:0] w0, w1;
      check("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      check("req_ready", 32'(req_ready),
            32'((exp_q.size() == 0) || (exp_q.size() == 1 && instr_ready)));
      check("err", 32'(err), 32'(exp_err));
      if (instr_valid && exp_q.size() != 0) begin
        check("instr", instr, exp_q[0].word);
        check("last", 32'(instr_last), 32'(exp_q[0].last));
      end
      if (rst) begin
        exp_q.delete();
        exp_err = 1'b0;
      end else begin
        if (instr_valid && instr_ready && exp_q.size() != 0) begin
          obs_q.push_back(instr);
          void'(exp_q.pop_front());
        end
        exp_err = 1'b0;
        if (req_valid && req_ready) begin
          model(req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7,
                req_imm, bad, n, w0, w1);
          if (bad) begin
            exp_err = 1'b1;
          end else begin
            exp_q.push_back('{word: w0, last: (n == 1)});
            if (n == 2) exp_q.push_back('{word: w1, last: 1'b1});
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    bit acc = 1'b0;
    req_fmt    = fmt;
    req_opcode = op;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm    = imm;
    req_valid  = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) instr_ready = ($urandom % 4) != 0;
    end
    req_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    instr_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom % 5)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      3:       return (32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000) & ~32'd1;
      default: return $urandom & 32'hFFFFF000;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    req_valid = 1'b0;
    instr_ready = 1'b1;
    req_fmt = '0; req_opcode = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_funct3 = '0; req_funct7 = '0; req_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_last", 32'(instr_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst = 1'b0;

    base = obs_q.size();
    send(3'd1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    drain();
    check("addi_word", obs_q[base], 32'hFFF30293);

    base = obs_q.size();
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    drain();
    check("li_lui_word", obs_q[base], 32'h12346537);
    check("li_addi_word", obs_q[base+1], 32'hFFF50513);

    base = obs_q.size();
    send(3'd6, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF);
    send(3'd6, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    drain();
    check("li_small_word", obs_q[base], 32'h7FF00093);
    check("li_lui_only_word", obs_q[base+1], 32'h000010B7);
    check("jal_word", obs_q[base+2], 32'h001000EF);

    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    check("b_odd_err", 32'(err), 32'(c_chk));
    check("b_odd_valid", 32'(instr_valid), 32'(!c_chk));
    drain();

    // Backpressure on both words of a two-word LI
    instr_ready = 1'b0;
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    repeat (3) begin
      @(negedge clk);
      check("bp_first_ready", 32'(req_ready), 32'd0);
      check("bp_first_word", instr, 32'h12346537);
    end
    @(posedge clk); #1; instr_ready = 1'b1;
    @(posedge clk); #1; instr_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_last_word", instr, 32'hFFF50513);
      check("bp_last_flag", 32'(instr_last), 32'd1);
    end
    @(posedge clk); #1; instr_ready = 1'b1;
    for (int k = 0; k < 6; k++)
      send(3'd1, 7'b0010011, 5'(k), 5'(k + 1), 5'd0, 3'(k), 7'd0, 32'(k * 100));
    drain();

    // Reset while the ADDI of an LI is still pending
    instr_ready = 1'b0;
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(instr_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    rand_rdy = 1'b1;
    repeat (300)
      send(3'($urandom % 8), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), rand_imm());
    rand_rdy = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cg_rvarch_instr_encoder.md
Name: cg_rvarch_instr_encoder

Overview:
- Streaming RV32 instruction encoder: the inverse of the instruction-field decode functions. Accepts opcode, register, funct and immediate fields and emits packed 32-bit instruction words.
- Also expands the LI pseudo-instruction into LUI/ADDI sequences.
- Used by test generators, boot-ROM builders and self-modifying-code stimulus in front of the fetch path.
- Valid/ready request in, valid/ready instruction stream out.

Parameters:
- INSTR_WIDTH, 32, instruction word width; only 32 is supported.
- ADDI_FUNCT3, 3'b000, funct3 used for the ADDI words emitted by LI expansion.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_req_valid  input  1  request valid.
- o_req_ready  output  1  request accepted when valid&&ready.
- i_req_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI; 7 is illegal.
- i_req_opcode  input  7  opcode[6:0]; ignored for LI.
- i_req_rd  input  5  destination register.
- i_req_rs1  input  5  source register 1.
- i_req_rs2  input  5  source register 2.
- i_req_funct3  input  3  funct3.
- i_req_funct7  input  7  funct7; R format only.
- i_req_imm  input  32  byte-offset / value immediate (signed).
- o_instr_valid  output  1  instruction word valid.
- i_instr_ready  input  1  downstream accept.
- o_instr  output  32  encoded instruction.
- o_instr_last  output  1  final word of the current request.
- o_err  output  1  one-cycle pulse: request rejected.

Behaviour:
- Reset: state IDLE; o_instr_valid=0, o_instr=0, o_instr_last=0, o_err=0, o_req_ready=1. Reset mid-sequence discards any pending second word.
- Packing (mirrors decode):
  - R: {funct7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- LI expansion:
  - If imm sign-fits 12 bits: one word, ADDI rd,x0,imm (opcode 0010011).
  - Otherwise: hi=(imm+32'h800)[31:12] (mod 2^32), lo=imm[11:0]. Emit LUI rd,hi (opcode 0110111).
  - If lo!=0, then also emit ADDI rd,rd,lo.
- State machine:
  - States: IDLE, HOLD_LAST (output holds the final word), HOLD_FIRST (output holds the LUI word, ADDI pending in a second register).
  - IDLE: accept a request, then go to HOLD_FIRST or HOLD_LAST, or stay in IDLE on error.
  - HOLD_FIRST: on i_instr_ready, load the ADDI word and go to HOLD_LAST.
  - HOLD_LAST: on i_instr_ready, go to IDLE, or accept a new request in the same cycle.
- Handshake:
  - o_req_ready = IDLE || (HOLD_LAST && i_instr_ready). Combinational from i_instr_ready; no path to i_req_valid.
  - Latency: request accepted in cycle N gives o_instr_valid in N+1.
  - Throughput: 1 word/cycle under continuous ready.
  - o_instr and o_instr_last are stable while valid && !ready.
- o_instr_last: 1 on single-word outputs and on the ADDI of a two-word LI; 0 on the LUI of a two-word LI.
- Error conditions:
  - fmt=7.
  - I/S imm outside [-2048, 2047].
  - B imm outside [-4096, 4094] or imm[0]=1.
  - J imm outside [-2^20, 2^20-2] or imm[0]=1.
  - U imm[11:0]!=0.
- Error handling:
  - The request is consumed and no word is emitted.
  - o_err pulses in N+1.
  - If the erroneous request was accepted from HOLD_LAST, the FSM goes to IDLE and o_instr_valid drops.
- Register fields x0..x31 are never checked.

Optional Feature:
- Macro: CG_RVARCH_ENC_CHECK_EN.
- Defined: range and alignment checking and o_err as specified.
- Undefined: no checks. Immediates are silently truncated to the format's fields (imm[0] dropped for B/J, imm[11:0] dropped for U), fmt=7 encodes as R, and o_err is tied 0.
- LI expansion is identical in both builds.

Test Plan:
- I-format ADDI, opcode 0010011, rd=5, rs1=6, f3=0, imm=32'hFFFFFFFF -> o_instr=32'hFFF30293, last=1, one cycle after accept.
- LI rd=10, imm=32'h12345FFF -> 32'h12346537 (last=0), then 32'h FFF50513 (last=1).
- LI rd=1, imm=32'h7FF -> single 32'h7FF00093, last=1. LI rd=1, imm=32'h1000 -> single LUI 32'h000010B7, last=1.
- J-format JAL, opcode 1101111, rd=1, imm=32'h800 -> 32'h001000EF.
- B-format, imm=3, with CHECK_EN -> o_err=1 for one cycle, o_instr_valid stays 0, o_req_ready=1 next cycle. Without CHECK_EN -> a word is emitted, o_err=0.
- Backpressure during LI 32'h12345FFF: i_instr_ready low for 3 cycles on each word -> words stable, o_req_ready=0 throughout HOLD_FIRST. Back-to-back requests then sustain 1 word/cycle. Assert i_rst while in HOLD_FIRST -> next cycle valid=0, ready=1, the ADDI is never emitted.
